// File: rtl/pc_redirect_controller_pkg.sv
// Shared types for the decode-stage PC redirect controller: FSM states,
// redirect source encoding and redirect counter sizing.
package pc_redirect_controller_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_JUMP   = 2'd1,
        SRC_BRANCH = 2'd2,
        SRC_JR     = 2'd3
    } src_t;

    localparam int COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/pc_redirect_controller_redirect_select.sv
// Priority select of the decode-stage redirect source (JR > branch > jump)
// and detection of more than one source requesting in the same cycle.
module redirect_select
    import pc_redirect_controller_pkg::*;
(
    input  logic        stall_d,
    input  logic        jump_valid_d,
    input  logic [31:0] jump_target_d,
    input  logic        branch_taken_d,
    input  logic [31:0] branch_target_d,
    input  logic        jr_valid_d,
    input  logic [31:0] jr_target_d,
    output logic        valid,
    output logic [31:0] target,
    output logic        conflict
);

    src_t src;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; that is what keeps a combinational block latch-free.
    always_comb begin
        src = SRC_SEQ;
        if (!stall_d) begin
            if (jr_valid_d)          src = SRC_JR;
            else if (branch_taken_d) src = SRC_BRANCH;
            else if (jump_valid_d)   src = SRC_JUMP;
        end
    end

    always_comb begin
        target = '0;
        case (src)
            SRC_JR:     target = jr_target_d;
            SRC_BRANCH: target = branch_target_d;
            SRC_JUMP:   target = jump_target_d;
            default:    target = '0;
        endcase
    end

    assign valid    = (src != SRC_SEQ);
    assign conflict = !stall_d && ((jr_valid_d && branch_taken_d) ||
                                   (jr_valid_d && jump_valid_d)   ||
                                   (branch_taken_d && jump_valid_d));

endmodule

// File: rtl/pc_redirect_controller.sv
// Decode-stage PC redirect sequencer: zero-cycle redirect when fetch is ready,
// otherwise captures the target and freezes the front end until it can replay.
module pc_redirect_controller
    import pc_redirect_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        pc_plus_four_f,
    input  logic               stall_d,
    input  logic               jump_valid_d,
    input  logic [31:0]        jump_target_d,
    input  logic               branch_taken_d,
    input  logic [31:0]        branch_target_d,
    input  logic               jr_valid_d,
    input  logic [31:0]        jr_target_d,
    input  logic               fetch_ready,
    output logic [31:0]        next_pc,
    output logic               pc_write,
    output logic               flush_d,
    output logic               hold_front,
    output logic               conflict_error,
    output logic [COUNT_W-1:0] redirect_count
);

    localparam logic REDIRECT_FLUSH = !DELAY_SLOT;

    state_t      state, state_nxt;
    logic [31:0] held_target;
    logic        req_valid;
    logic [31:0] req_target;
    logic        req_conflict;
    logic        capture;
    logic        commit;

    redirect_select u_select (
        .stall_d         (stall_d),
        .jump_valid_d    (jump_valid_d),
        .jump_target_d   (jump_target_d),
        .branch_taken_d  (branch_taken_d),
        .branch_target_d (branch_target_d),
        .jr_valid_d      (jr_valid_d),
        .jr_target_d     (jr_target_d),
        .valid           (req_valid),
        .target          (req_target),
        .conflict        (req_conflict)
    );

    always_comb begin
        state_nxt  = state;
        next_pc    = pc_plus_four_f;
        pc_write   = 1'b0;
        flush_d    = 1'b0;
        hold_front = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        if (reset) begin
            next_pc   = RESET_PC;
            pc_write  = 1'b1;
            flush_d   = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        next_pc = req_target;
                        if (fetch_ready) begin
                            pc_write = 1'b1;
                            flush_d  = REDIRECT_FLUSH;
                            commit   = 1'b1;
                        end else begin
                            capture   = 1'b1;
                            state_nxt = HOLD;
                        end
                    end else begin
                        pc_write = fetch_ready && !stall_d;
                    end
                end
                HOLD: begin
                    // Decode-stage requests are deliberately ignored here; the
                    // held redirect is the only thing allowed to move the PC.
                    hold_front = 1'b1;
                    next_pc    = held_target;
                    if (fetch_ready) begin
                        pc_write  = 1'b1;
                        flush_d   = REDIRECT_FLUSH;
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            held_target    <= '0;
            conflict_error <= 1'b0;
            redirect_count <= '0;
        end else begin
            state <= state_nxt;
            if (capture)
                held_target <= req_target;
            if (req_conflict)
                conflict_error <= 1'b1;
            if (commit && (redirect_count != COUNT_MAX))
                redirect_count <= redirect_count + 1'b1;
        end
    end

endmodule
